x_debounce: RTL and testbench

X_DEBOUNCE -- requirements
Module: x_debounce

---
 rtl/x_debounce.sv | 108 ++++++++++
 tb/tb_x_debounce.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/x_debounce.sv
// rtl/x_debounce.sv - push-button debouncer emitting one x_out pulse per accepted press
// Two-flop synchronizer feeding a four-state debounce FSM with a saturating glitch counter.
module x_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       btn_raw,
   output logic       x_out,
   output logic       btn_level,
   output logic [7:0] glitch_cnt
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             btn_s;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign btn_s = sync2;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         cnt        <= '0;
         x_out      <= 1'b0;
         btn_level  <= 1'b0;
         glitch_cnt <= 8'd0;
      end else begin
         x_out <= 1'b0;
         case (state)
            IDLE: begin
               btn_level <= 1'b0;
               if (btn_s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (btn_s) begin
                  if (cnt == CNT_LAST) begin
                     state     <= PRESSED;
                     x_out     <= 1'b1;
                     btn_level <= 1'b1;
                     cnt       <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  cnt   <= '0;
                  if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
               end
            end
            PRESSED: begin
               btn_level <= 1'b1;
               if (!btn_s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (!btn_s) begin
                  if (cnt == CNT_LAST) begin
                     state     <= IDLE;
                     btn_level <= 1'b0;
                     cnt       <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  // Release bounce: the button is still held, so level stays high.
                  state <= PRESSED;
                  cnt   <= '0;
                  if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               x_out     <= 1'b0;
               btn_level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_x_debounce.sv
// tb/tb_x_debounce.sv - randomized self-checking bench for x_debounce
// Reference model tracks the accepted level and the run length of disagreeing samples.
module tb_x_debounce;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       btn_raw = 1'b0;
   logic       x_out;
   logic       btn_level;
   logic [7:0] glitch_cnt;

   x_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .btn_raw    (btn_raw),
      .x_out      (x_out),
      .btn_level  (btn_level),
      .glitch_cnt (glitch_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   bit m_s1, m_s2, m_lvl, m_pulse;
   int m_run, m_glitch;

   int edge_no = 0;
   int dut_pulses = 0;
   int last_pulse_edge = -1;
   int p0, g0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pulse = 0;
      m_run = 0; m_glitch = 0;
   endtask

   task automatic step(input bit b);
      bit bs;
      btn_raw = b;
      @(posedge clk);
      edge_no++;
      if (!rstn) begin
         model_reset();
      end else begin
         bs = m_s2;
         m_s2 = m_s1;
         m_s1 = btn_raw;
         m_pulse = 0;
         if (bs != m_lvl) begin
            m_run++;
            if (m_run == D + 1) begin
               m_lvl = bs;
               m_run = 0;
               m_pulse = bs;
            end
         end else begin
            if (m_run > 0 && m_glitch < 255) m_glitch++;
            m_run = 0;
         end
      end
      #1;
      if (x_out === 1'b1) begin
         dut_pulses++;
         last_pulse_edge = edge_no;
      end
      check("x_out", int'(x_out), int'(m_pulse));
      check("btn_level", int'(btn_level), int'(m_lvl));
      check("glitch_cnt", int'(glitch_cnt), m_glitch);
   endtask

   task automatic async_reset_check();
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      check("rst_x_out", int'(x_out), 0);
      check("rst_btn_level", int'(btn_level), 0);
      check("rst_glitch_cnt", int'(glitch_cnt), 0);
   endtask

   task automatic hold(input bit b, input int n);
      for (int i = 0; i < n; i++) step(b);
   endtask

   initial begin
      bit lvl;
      model_reset();
      #1;
      check("reset_x_out", int'(x_out), 0);
      check("reset_btn_level", int'(btn_level), 0);
      check("reset_glitch_cnt", int'(glitch_cnt), 0);
      hold(0, 3);
      rstn = 1'b1;

      // Clean press
      edge_no = 0; p0 = dut_pulses;
      hold(1, 20);
      check("clean_pulse_edge", last_pulse_edge, 7);
      check("clean_pulse_count", dut_pulses - p0, 1);
      check("clean_level", int'(btn_level), 1);
      check("clean_glitch", int'(glitch_cnt), 0);
      hold(0, 10);

      // Bounce on press
      edge_no = 0; p0 = dut_pulses;
      hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 2);
      hold(1, 15);
      check("bounce_pulse_edge", last_pulse_edge, 15);
      check("bounce_pulse_count", dut_pulses - p0, 1);
      check("bounce_glitch_ge1", int'(glitch_cnt >= 8'd1), 1);
      hold(0, 12);

      // Bounce on release
      hold(1, 12);
      g0 = int'(glitch_cnt); p0 = dut_pulses;
      hold(0, 2);
      hold(1, 10);
      check("rel_bounce_pulses", dut_pulses - p0, 0);
      check("rel_bounce_level", int'(btn_level), 1);
      check("rel_bounce_glitch", int'(glitch_cnt), g0 + 1);
      hold(0, 10);

      // Five clean presses advance the downstream counter S0 -> S5
      p0 = dut_pulses;
      for (int k = 0; k < 5; k++) begin
         hold(1, 10);
         hold(0, 10);
      end
      check("S0_to_S5", dut_pulses - p0, 5);

      // Reset mid-wait, released with the button still held
      hold(1, 2);
      async_reset_check();
      hold(1, 2);
      rstn = 1'b1;
      edge_no = 0; p0 = dut_pulses;
      hold(1, 10);
      check("rst_release_pulse_edge", last_pulse_edge, 7);
      check("rst_release_pulses", dut_pulses - p0, 1);
      hold(0, 10);

      // Saturation
      for (int k = 0; k < 300; k++) begin
         step(1);
         step(0);
      end
      hold(0, 4);
      check("sat_255", int'(glitch_cnt), 255);
      for (int k = 0; k < 10; k++) begin
         step(1);
         step(0);
      end
      hold(0, 4);
      check("sat_hold", int'(glitch_cnt), 255);

      // Random run lengths with occasional asynchronous reset
      lvl = 1'b0;
      for (int seg = 0; seg < 400; seg++) begin
         lvl = ~lvl;
         hold(lvl, int'($urandom_range(1, 9)));
         if ($urandom_range(0, 39) == 0) begin
            async_reset_check();
            hold(lvl, int'($urandom_range(1, 3)));
            rstn = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
